// File: rtl/mer_meas_ctrl.sv
// MER measurement sequencer: settle, calibrate the reference over one LFSR period,
// then freeze it and accumulate error over MEAS_CYCLES periods, latching the results.
module mer_meas_ctrl #(
    parameter int SETTLE_SYMS = 16,
    parameter int MEAS_CYCLES = 1,
    parameter int ERR_CNT_W   = 24
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clk_en_i,
    input  logic                     start_i,
    input  logic                     continuous_i,
    input  logic                     abort_i,
    input  logic                     lfsr_cycle_periodic_i,
    input  logic                     sym_error_i,
    input  logic signed [17:0]       acc_sq_in_i,
    input  logic signed [17:0]       acc_dc_in_i,
    output logic                     ref_hold_o,
    output logic                     acc_clear_o,
    output logic                     busy_o,
    output logic [2:0]               state_o,
    output logic                     result_valid_o,
    output logic signed [17:0]       mer_sq_o,
    output logic signed [17:0]       mer_dc_o,
    output logic [ERR_CNT_W-1:0]     sym_err_count_o,
    output logic [15:0]              meas_count_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETTLE    = 3'd1;
    localparam logic [2:0] S_CAL_ALIGN = 3'd2;
    localparam logic [2:0] S_CAL       = 3'd3;
    localparam logic [2:0] S_MEAS      = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam int SET_W = $clog2(SETTLE_SYMS + 1);
    localparam int CYC_W = $clog2(MEAS_CYCLES + 1);

    logic [2:0]              state_q, state_d;
    logic                    pend_q, pend_d;
    logic                    ref_hold_q, ref_hold_d;
    logic [SET_W-1:0]        settle_q, settle_d;
    logic [CYC_W-1:0]        cyc_q, cyc_d;
    logic [ERR_CNT_W-1:0]    err_q, err_d;
    logic signed [17:0]      mer_sq_q, mer_sq_d;
    logic signed [17:0]      mer_dc_q, mer_dc_d;
    logic [ERR_CNT_W-1:0]    err_out_q, err_out_d;
    logic [15:0]             meas_q, meas_d;
    logic                    enter_meas;
    logic                    latch;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        settle_d   = settle_q;
        cyc_d      = cyc_q;
        err_d      = err_q;
        mer_sq_d   = mer_sq_q;
        mer_dc_d   = mer_dc_q;
        err_out_d  = err_out_q;
        meas_d     = meas_q;
        enter_meas = 1'b0;
        latch      = 1'b0;

        // A start while busy is dropped rather than queued.
        if (start_i && state_q == S_IDLE)
            pend_d = 1'b1;

        if (clk_en_i) begin
            case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        state_d  = S_SETTLE;
                        settle_d = '0;
                        pend_d   = 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_SYMS - 1))
                        state_d = S_CAL_ALIGN;
                    else
                        settle_d = settle_q + 1'b1;
                end
                S_CAL_ALIGN: begin
                    if (lfsr_cycle_periodic_i)
                        state_d = S_CAL;
                end
                S_CAL: begin
                    if (lfsr_cycle_periodic_i)
                        enter_meas = 1'b1;
                end
                S_MEAS: begin
                    if (sym_error_i && err_q != '1)
                        err_d = err_q + 1'b1;
                    if (lfsr_cycle_periodic_i) begin
                        cyc_d = cyc_q + 1'b1;
                        if (cyc_q == CYC_W'(MEAS_CYCLES - 1))
                            state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    latch = 1'b1;
                    if (continuous_i)
                        enter_meas = 1'b1;
                    else
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (abort_i) begin
            state_d    = S_IDLE;
            pend_d     = 1'b0;
            enter_meas = 1'b0;
            latch      = 1'b0;
        end

        if (enter_meas) begin
            state_d = S_MEAS;
            cyc_d   = '0;
            err_d   = '0;
        end

        if (latch) begin
            mer_sq_d  = acc_sq_in_i;
            mer_dc_d  = acc_dc_in_i;
            err_out_d = err_q;
            meas_d    = meas_q + 16'd1;
        end

        // The reference stays frozen for the whole MEAS/DONE span, including re-arms.
        ref_hold_d = (state_d == S_MEAS) || (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            pend_q     <= 1'b0;
            ref_hold_q <= 1'b0;
            settle_q   <= '0;
            cyc_q      <= '0;
            err_q      <= '0;
            mer_sq_q   <= '0;
            mer_dc_q   <= '0;
            err_out_q  <= '0;
            meas_q     <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            ref_hold_q <= ref_hold_d;
            settle_q   <= settle_d;
            cyc_q      <= cyc_d;
            err_q      <= err_d;
            mer_sq_q   <= mer_sq_d;
            mer_dc_q   <= mer_dc_d;
            err_out_q  <= err_out_d;
            meas_q     <= meas_d;
        end
    end

    // Strobes coincide with the qualifying clk_en so downstream enables see them.
    assign acc_clear_o     = enter_meas & ~reset_i;
    assign result_valid_o  = latch & ~reset_i;
    assign ref_hold_o      = ref_hold_q;
    assign busy_o          = (state_q != S_IDLE);
    assign state_o         = state_q;
    assign mer_sq_o        = mer_sq_q;
    assign mer_dc_o        = mer_dc_q;
    assign sym_err_count_o = err_out_q;
    assign meas_count_o    = meas_q;

endmodule
